keypad_digit_encoder: RTL and testbench

- Scans a 4x4 active-low matrix keypad, debounces the key, and encodes it to a 4-bit code.
- Delivers each key press as a one-cycle `enter` strobe with a stable `digit`. This is the digit/enter interface consumed by `fsm_password_lock`.
- Sits between the board keypad pins and the lock FSM, replacing bench-driven digit/enter stimulus in hardware.

---
 rtl/keypad_digit_encoder_if.sv | 21 ++
 rtl/keypad_digit_encoder.sv | 143 ++++++++++++++
 tb/tb_keypad_digit_encoder.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_digit_encoder_if.sv
// Keypad-side signal bundle: row sense in, column drive out, plus the digit/enter
// interface delivered to the lock FSM.
interface keypad_digit_encoder_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] digit;
  logic       enter;
  logic       key_held;

  // master: board/keypad side that drives rows and consumes the encoded key
  modport master (
    output row_in,
    input  col_out, digit, enter, key_held
  );

  // slave: the encoder itself
  modport slave (
    input  row_in,
    output col_out, digit, enter, key_held
  );
endinterface

// File: rtl/keypad_digit_encoder.sv
// 4x4 active-low matrix keypad scanner with press/release debounce, emitting one
// enter strobe and a held 4-bit code per accepted key press.
module keypad_digit_encoder #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  keypad_digit_encoder_if.slave  kp
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;

  logic [DW-1:0] div_cnt;
  logic [1:0]    state;
  logic [1:0]    col_idx;
  logic [3:0]    col_reg;
  logic [3:0]    row_lat;
  logic [3:0]    digit_reg;
  logic          enter_reg;
  logic          held_reg;
  logic [CW-1:0] stable_cnt;
  logic [CW-1:0] rel_cnt;

  logic       sample;
  logic       one_low;
  logic       match;
  logic       all_high;
  logic       accept;
  logic       advance;
  logic [3:0] code_now;

  function automatic logic [3:0] key_code(input logic [3:0] rows, input logic [1:0] col);
    logic [1:0] r;
    logic [3:0] code;
    case (rows)
      4'b1110: r = 2'd0;
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      default: r = 2'd3;
    endcase
    case ({r, col})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign sample   = (div_cnt == DW'(SCAN_DIV - 1));
  assign match    = (kp.row_in == row_lat);
  assign all_high = (kp.row_in == 4'hF);
  // On a match row_in equals row_lat, so the live rows give the same code.
  assign code_now = key_code(kp.row_in, col_idx);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    one_low = 1'b0;
    case (kp.row_in)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
      default:                            one_low = 1'b0;
    endcase
  end

  assign accept = sample &&
                  (((state == ST_SCAN) && one_low && (DEBOUNCE == 1)) ||
                   ((state == ST_DEBOUNCE) && match && (stable_cnt == CW'(DEBOUNCE - 1))));

  assign advance = sample &&
                   (((state == ST_SCAN) && !one_low) ||
                    ((state == ST_DEBOUNCE) && !match) ||
                    ((state == ST_HOLD) && all_high && (rel_cnt == CW'(DEBOUNCE - 1))));

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt    <= '0;
      state      <= ST_SCAN;
      col_idx    <= 2'd0;
      col_reg    <= 4'b1110;
      row_lat    <= 4'hF;
      digit_reg  <= 4'h0;
      enter_reg  <= 1'b0;
      held_reg   <= 1'b0;
      stable_cnt <= '0;
      rel_cnt    <= '0;
    end else begin
      enter_reg <= 1'b0;
      div_cnt   <= sample ? '0 : div_cnt + DW'(1);

      if (advance) begin
        col_idx <= col_idx + 2'd1;
        col_reg <= {col_reg[2:0], col_reg[3]};
      end

      if (accept) begin
        digit_reg <= code_now;
        enter_reg <= 1'b1;
        held_reg  <= 1'b1;
        rel_cnt   <= '0;
        state     <= ST_HOLD;
      end else if (sample) begin
        case (state)
          ST_SCAN: begin
            if (one_low) begin
              row_lat    <= kp.row_in;
              stable_cnt <= CW'(1);
              state      <= ST_DEBOUNCE;
            end
          end
          ST_DEBOUNCE: begin
            if (match) stable_cnt <= stable_cnt + CW'(1);
            else       state      <= ST_SCAN;
          end
          ST_HOLD: begin
            if (!all_high) begin
              rel_cnt <= '0;
            end else if (rel_cnt == CW'(DEBOUNCE - 1)) begin
              held_reg <= 1'b0;
              state    <= ST_SCAN;
            end else begin
              rel_cnt <= rel_cnt + CW'(1);
            end
          end
          default: state <= ST_SCAN;
        endcase
      end
    end
  end

  assign kp.col_out  = col_reg;
  assign kp.digit    = digit_reg;
  assign kp.enter    = enter_reg;
  assign kp.key_held = held_reg;

endmodule

// File: tb/tb_keypad_digit_encoder.sv
// Directed bench for keypad_digit_encoder: a behavioural 4x4 matrix drives the rows
// from the driven column, and each scenario task checks its own expectations.
module tb_keypad_digit_encoder;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  keypad_digit_encoder_if kif();

  keypad_digit_encoder #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kif.slave)
  );

  // Pressed-key matrix, bit index r*4+c; a row reads low when a pressed key sits
  // in the column currently driven low.
  logic [15:0] pressed = '0;
  logic [3:0]  rows;
  always_comb begin
    rows = 4'hF;
    for (int c = 0; c < 4; c++)
      if (kif.col_out[c] === 1'b0)
        for (int r = 0; r < 4; r++)
          if (pressed[r*4+c]) rows[r] = 1'b0;
  end
  assign kif.row_in = rows;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int enter_cnt = 0;
  int enter_cyc = 0;
  int colchg_cyc = 0;
  int colchg_cnt = 0;
  logic [3:0] enter_digit = 4'h0;
  logic [3:0] prev_col = 4'b1110;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (kif.enter === 1'b1) begin
      enter_cnt   <= enter_cnt + 1;
      enter_cyc   <= cyc;
      enter_digit <= kif.digit;
    end
    if (kif.col_out !== prev_col) begin
      colchg_cnt <= colchg_cnt + 1;
      colchg_cyc <= cyc;
      prev_col   <= kif.col_out;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_enter(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (enter_cnt > base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_col(input logic [3:0] value, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (kif.col_out === value) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic wait_released(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (kif.key_held === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    reset = 1'b0;
    tick(3);
    total++; if (kif.col_out !== 4'b1110) begin bad++; $display("FAIL reset_col: got %b want 1110", kif.col_out); end
    total++; if (kif.digit !== 4'h0) begin bad++; $display("FAIL reset_digit: got %h want 0", kif.digit); end
    total++; if (kif.enter !== 1'b0) begin bad++; $display("FAIL reset_enter: got %b want 0", kif.enter); end
    total++; if (kif.key_held !== 1'b0) begin bad++; $display("FAIL reset_held: got %b want 0", kif.key_held); end
    reset = 1'b1;
    // After the n-th edge following release the column index is (n/4) mod 4.
    for (int n = 1; n <= 16; n++) begin
      tick(1);
      exp_col = ~(4'b0001 << ((n / 4) % 4));
      total++;
      if (kif.col_out !== exp_col) begin
        bad++; $display("FAIL scan_step%0d: got %b want %b", n, kif.col_out, exp_col);
      end
    end
    total++; if (enter_cnt !== 0) begin bad++; $display("FAIL idle_strobe: got %0d want 0", enter_cnt); end
  endtask

  task automatic test_single_press();
    int base;
    bit ok;
    wait_col(4'b1101, 40, ok);
    base = enter_cnt;
    pressed = 16'h0 | (16'h1 << (1*4+2));
    wait_enter(base, 60, ok);
    total++; if (!ok) begin bad++; $display("FAIL press_timeout: no enter, want one"); end
    total++; if (enter_digit !== 4'h6) begin bad++; $display("FAIL press_digit: got %h want 6", enter_digit); end
    total++; if (enter_cyc - colchg_cyc !== 12) begin bad++; $display("FAIL press_latency: got %0d want 12 (col change to strobe)", enter_cyc - colchg_cyc); end
    total++; if (kif.enter !== 1'b0) begin bad++; $display("FAIL press_width: enter=%b one cycle later, want 0", kif.enter); end
    total++; if (kif.key_held !== 1'b1) begin bad++; $display("FAIL press_held: got %b want 1", kif.key_held); end
    tick(28);
    total++; if (enter_cnt - base !== 1) begin bad++; $display("FAIL press_count: got %0d want 1", enter_cnt - base); end
    total++; if (kif.key_held !== 1'b1) begin bad++; $display("FAIL press_still_held: got %b want 1", kif.key_held); end
    pressed = '0;
    tick(8);
    total++; if (kif.key_held !== 1'b1) begin bad++; $display("FAIL release_early: got %b want 1", kif.key_held); end
    wait_released(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL release_timeout: key_held stuck, want 0"); end
    total++; if (kif.digit !== 4'h6) begin bad++; $display("FAIL digit_hold: got %h want 6", kif.digit); end
  endtask

  task automatic test_password();
    int base;
    bit ok;
    int         key_bit [4] = '{1*4+0, 0*4+2, 0*4+1, 0*4+0};
    logic [3:0] key_val [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    base = enter_cnt;
    for (int k = 0; k < 4; k++) begin
      pressed = 16'h1 << key_bit[k];
      wait_enter(base + k, 100, ok);
      total++; if (!ok || enter_digit !== key_val[k]) begin
        bad++; $display("FAIL pw_key%0d: got %h ok=%0d want %h", k, enter_digit, ok, key_val[k]);
      end
      pressed = '0;
      wait_released(40, ok);
      total++; if (!ok) begin bad++; $display("FAIL pw_release%0d: key_held stuck, want 0", k); end
    end
    total++; if (enter_cnt - base !== 4) begin bad++; $display("FAIL pw_count: got %0d want 4", enter_cnt - base); end
  endtask

  task automatic test_bounce();
    int base;
    bit ok;
    base = enter_cnt;
    for (int i = 0; i < 10; i++) begin
      pressed[0] = (i % 2 == 0);
      tick(3);
    end
    total++; if (enter_cnt - base !== 0) begin bad++; $display("FAIL bounce_strobe: got %0d want 0", enter_cnt - base); end
    pressed[0] = 1'b1;
    wait_enter(base, 100, ok);
    total++; if (!ok || enter_digit !== 4'h1) begin bad++; $display("FAIL bounce_digit: got %h ok=%0d want 1", enter_digit, ok); end
    tick(30);
    total++; if (enter_cnt - base !== 1) begin bad++; $display("FAIL bounce_count: got %0d want 1", enter_cnt - base); end
    pressed = '0;
    wait_released(40, ok);
    total++; if (!ok) begin bad++; $display("FAIL bounce_release: key_held stuck, want 0"); end
  endtask

  task automatic test_multi_key();
    int base;
    int cc;
    bit ok;
    base = enter_cnt;
    cc   = colchg_cnt;
    pressed = (16'h1 << (0*4+1)) | (16'h1 << (1*4+1));
    tick(40);
    total++; if (enter_cnt - base !== 0) begin bad++; $display("FAIL multi_strobe: got %0d want 0", enter_cnt - base); end
    total++; if (colchg_cnt - cc < 8) begin bad++; $display("FAIL multi_rotate: got %0d col steps want >=8", colchg_cnt - cc); end
    pressed = 16'h1 << (3*4+1);
    wait_enter(base, 100, ok);
    total++; if (!ok || enter_digit !== 4'h0) begin bad++; $display("FAIL held_r3c1: got %h ok=%0d want 0", enter_digit, ok); end
    pressed[0*4+3] = 1'b1;
    tick(60);
    total++; if (enter_cnt - base !== 1) begin bad++; $display("FAIL frozen_count: got %0d want 1", enter_cnt - base); end
    total++; if (kif.digit !== 4'h0) begin bad++; $display("FAIL frozen_digit: got %h want 0", kif.digit); end
    pressed[3*4+1] = 1'b0;
    wait_enter(base + 1, 100, ok);
    total++; if (!ok || enter_digit !== 4'hA) begin bad++; $display("FAIL after_release: got %h ok=%0d want a", enter_digit, ok); end
    pressed = '0;
    wait_released(40, ok);
    total++; if (!ok) begin bad++; $display("FAIL multi_release: key_held stuck, want 0"); end
  endtask

  task automatic test_reset_mid();
    int base;
    bit ok;
    wait_col(4'b1101, 40, ok);
    base = enter_cnt;
    pressed = 16'h1 << (3*4+2);
    wait_col(4'b1011, 20, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_col_timeout: col %b want 1011", kif.col_out); end
    tick(9);
    total++; if (enter_cnt - base !== 0) begin bad++; $display("FAIL mid_early_strobe: got %0d want 0", enter_cnt - base); end
    reset = 1'b0;
    tick(1);
    total++; if (kif.col_out !== 4'b1110 || kif.key_held !== 1'b0 || kif.digit !== 4'h0) begin
      bad++; $display("FAIL mid_reset_state: col=%b held=%b digit=%h want 1110/0/0", kif.col_out, kif.key_held, kif.digit);
    end
    tick(2);
    total++; if (enter_cnt - base !== 0) begin bad++; $display("FAIL mid_reset_strobe: got %0d want 0", enter_cnt - base); end
    reset = 1'b1;
    wait_enter(base, 100, ok);
    total++; if (!ok || enter_digit !== 4'hF) begin bad++; $display("FAIL mid_digit: got %h ok=%0d want f", enter_digit, ok); end
    total++; if (enter_cyc - colchg_cyc !== 12) begin bad++; $display("FAIL mid_latency: got %0d want 12", enter_cyc - colchg_cyc); end
    tick(20);
    total++; if (enter_cnt - base !== 1) begin bad++; $display("FAIL mid_count: got %0d want 1", enter_cnt - base); end
    pressed = '0;
    wait_released(40, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_release: key_held stuck, want 0"); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_password();
    test_bounce();
    test_multi_key();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
